// File: rtl/mcash_wbuf_pkg.sv
// mcash_wbuf_pkg: shared entry-state encoding and channel-id width for the write buffer
package mcash_wbuf_pkg;
    localparam int CH_W = 2;
    localparam logic [1:0] ST_FREE    = 2'b00;
    localparam logic [1:0] ST_FILLED  = 2'b01;
    localparam logic [1:0] ST_PENDING = 2'b10;
endpackage

// File: rtl/wbuf_alloc_pick.sv
// wbuf_alloc_pick: priority picker returning the lowest-index free entry
module wbuf_alloc_pick #(
    parameter int ENTRIES = 8
) (
    input  logic [ENTRIES-1:0]         free,
    output logic                       found,
    output logic [$clog2(ENTRIES)-1:0] index
);
    localparam int AW = $clog2(ENTRIES);
    assign found = |free;
    // scan downwards so the last hit written is the lowest free index
    always_comb begin
        index = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (free[i]) index = AW'(i);
    end
endmodule

// File: rtl/bank_write_buffer.sv
// bank_write_buffer: write-data staging buffer between xbar and SRAM controller with 1-cycle return
module bank_write_buffer
    import mcash_wbuf_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int DW      = 128,
    parameter int IDW     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       xbar_wbuf_valid_i,
    output logic                       xbar_wbuf_ready_o,
    input  logic [CH_W-1:0]            xbar_wbuf_channel_id_i,
    input  logic [DW-1:0]              xbar_wbuf_data_i,
    output logic [IDW-1:0]             xbar_wbuf_wbuffer_id_o,
    input  logic                       rc_wbuf_req_valid_i,
    output logic                       rc_wbuf_req_ready_o,
    input  logic [CH_W-1:0]            rc_wbuf_req_channel_id_i,
    input  logic [IDW-1:0]             rc_wbuf_req_wbuffer_id_i,
    output logic                       rc_wbuf_rtn_valid_o,
    input  logic                       rc_wbuf_rtn_ready_i,
    output logic [DW-1:0]              rc_wbuf_rtn_data_o,
    output logic [$clog2(ENTRIES):0]   wbuf_count_o,
    output logic                       wbuf_err_o
);
    localparam int AW = $clog2(ENTRIES);
    localparam int CW = AW + 1;

    logic [1:0]        state [ENTRIES];
    logic [CH_W-1:0]   chan  [ENTRIES];
    logic [DW-1:0]     data  [ENTRIES];
    logic [ENTRIES-1:0] free_vec;
    logic              found;
    logic [AW-1:0]     alloc_idx;
    logic [AW-1:0]     req_slot;
    logic [AW-1:0]     pend_ptr;
    logic              pend_legal;
    logic              in_range, hit_filled, chan_ok, req_legal, req_illegal;
    logic              rtn_free, xbar_hs, req_hs, rtn_hs, frees_entry;

    // free map from registered state only, so a just-freed entry waits a cycle
    always_comb begin
        free_vec = '0;
        for (int i = 0; i < ENTRIES; i++) free_vec[i] = (state[i] == ST_FREE);
    end

    wbuf_alloc_pick #(.ENTRIES(ENTRIES)) u_pick (
        .free  (free_vec),
        .found (found),
        .index (alloc_idx)
    );

    assign xbar_wbuf_ready_o      = found;
    assign xbar_wbuf_wbuffer_id_o = IDW'(alloc_idx);
    assign xbar_hs                = xbar_wbuf_valid_i && found;

    assign req_slot    = rc_wbuf_req_wbuffer_id_i[AW-1:0];
    assign in_range    = 32'(rc_wbuf_req_wbuffer_id_i) < ENTRIES;
    assign hit_filled  = state[req_slot] == ST_FILLED;
    assign chan_ok     = chan[req_slot] == rc_wbuf_req_channel_id_i;
    assign req_legal   = in_range && hit_filled && chan_ok;
    assign req_illegal = !in_range || (hit_filled && !chan_ok);
    assign rtn_free    = !rc_wbuf_rtn_valid_o || rc_wbuf_rtn_ready_i;
    assign rc_wbuf_req_ready_o = rtn_free && (req_legal || req_illegal);
    assign req_hs      = rc_wbuf_req_valid_i && rc_wbuf_req_ready_o;
    assign rtn_hs      = rc_wbuf_rtn_valid_o && rc_wbuf_rtn_ready_i;
    assign frees_entry = rtn_hs && pend_legal;

    // entry lifecycle: the three transitions always target distinct entries
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) state[i] <= ST_FREE;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (frees_entry && pend_ptr == AW'(i)) state[i] <= ST_FREE;
                if (req_hs && req_legal && req_slot == AW'(i)) state[i] <= ST_PENDING;
                if (xbar_hs && alloc_idx == AW'(i)) state[i] <= ST_FILLED;
            end
        end
    end

    // payload storage carries no reset; state alone decides validity
    always_ff @(posedge clk_i) begin
        if (xbar_hs) begin
            data[alloc_idx] <= xbar_wbuf_data_i;
            chan[alloc_idx] <= xbar_wbuf_channel_id_i;
        end
    end

    // return register, pending pointer, occupancy and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rc_wbuf_rtn_valid_o <= 1'b0;
            rc_wbuf_rtn_data_o  <= '0;
            pend_ptr            <= '0;
            pend_legal          <= 1'b0;
            wbuf_count_o        <= '0;
            wbuf_err_o          <= 1'b0;
        end else begin
            if (req_hs) begin
                rc_wbuf_rtn_valid_o <= 1'b1;
                rc_wbuf_rtn_data_o  <= req_legal ? data[req_slot] : '0;
                pend_ptr            <= req_slot;
                pend_legal          <= req_legal;
            end else if (rtn_hs) begin
                rc_wbuf_rtn_valid_o <= 1'b0;
            end
            if (req_hs && req_illegal) wbuf_err_o <= 1'b1;
            wbuf_count_o <= wbuf_count_o + CW'(xbar_hs) - CW'(frees_entry);
        end
    end
endmodule

// File: tb/tb_bank_write_buffer.sv
// tb_bank_write_buffer: directed plus randomized checks against a behavioural buffer model
module tb_bank_write_buffer;
    localparam int ENTRIES = 8;
    localparam int DW = 128;
    localparam int IDW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic xv = 1'b0, xr;
    logic [1:0] xch = '0;
    logic [DW-1:0] xd = '0;
    logic [IDW-1:0] xid;
    logic qv = 1'b0, qr;
    logic [1:0] qch = '0;
    logic [IDW-1:0] qid = '0;
    logic rv, rr = 1'b0;
    logic [DW-1:0] rd;
    logic [3:0] cnt;
    logic err;

    int n_tests = 0;
    int n_fail = 0;

    int m_st [ENTRIES];
    int m_ch [ENTRIES];
    logic [DW-1:0] m_d [ENTRIES];
    bit m_rv, m_pl, m_err;
    logic [DW-1:0] m_rd;
    int m_pp;

    always #5 clk = ~clk;

    bank_write_buffer #(.ENTRIES(ENTRIES), .DW(DW), .IDW(IDW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .xbar_wbuf_valid_i(xv), .xbar_wbuf_ready_o(xr), .xbar_wbuf_channel_id_i(xch),
        .xbar_wbuf_data_i(xd), .xbar_wbuf_wbuffer_id_o(xid),
        .rc_wbuf_req_valid_i(qv), .rc_wbuf_req_ready_o(qr), .rc_wbuf_req_channel_id_i(qch),
        .rc_wbuf_req_wbuffer_id_i(qid),
        .rc_wbuf_rtn_valid_o(rv), .rc_wbuf_rtn_ready_i(rr), .rc_wbuf_rtn_data_o(rd),
        .wbuf_count_o(cnt), .wbuf_err_o(err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_st[i] = 0;
            m_ch[i] = 0;
        end
        m_rv = 0; m_pl = 0; m_err = 0; m_rd = '0; m_pp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge rst_n) model_reset();

    // model: 0=free 1=filled 2=pending; compare then advance to post-edge state
    always @(negedge clk) begin
        automatic int low = -1;
        automatic int occ = 0;
        automatic int id = int'(qid);
        automatic bit inr, lg, il, ereq, xh, qh, th;
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_st[i] == 0 && low < 0) low = i;
            if (m_st[i] != 0) occ++;
        end
        inr = id < ENTRIES;
        lg = inr && m_st[id % ENTRIES] == 1 && m_ch[id % ENTRIES] == int'(qch);
        il = !inr || (m_st[id % ENTRIES] == 1 && m_ch[id % ENTRIES] != int'(qch));
        ereq = (!m_rv || rr) && (lg || il);
        chk("xbar_ready", DW'(xr), DW'(low >= 0));
        if (low >= 0) chk("xbar_id", DW'(xid), DW'(low));
        chk("req_ready", DW'(qr), DW'(ereq));
        chk("rtn_valid", DW'(rv), DW'(m_rv));
        if (m_rv || !rst_n) chk("rtn_data", rd, m_rd);
        chk("count", DW'(cnt), DW'(occ));
        chk("err", DW'(err), DW'(m_err));
        if (rst_n) begin
            xh = xv && low >= 0;
            qh = qv && ereq;
            th = m_rv && rr;
            if (th && m_pl) m_st[m_pp] = 0;
            if (qh) begin
                if (lg) m_st[id] = 2;
                m_rd = lg ? m_d[id] : '0;
                m_pp = id % ENTRIES;
                m_pl = lg;
                m_rv = 1;
                if (il) m_err = 1;
            end else if (th) m_rv = 0;
            if (xh) begin
                m_st[low] = 1;
                m_ch[low] = int'(xch);
                m_d[low] = xd;
            end
        end
    end

    initial begin
        model_reset();
        #2;
        chk("rst_xbar_ready", DW'(xr), DW'(1));
        chk("rst_xbar_id", DW'(xid), DW'(0));
        chk("rst_count", DW'(cnt), DW'(0));
        chk("rst_rtn_valid", DW'(rv), DW'(0));
        chk("rst_rtn_data", rd, '0);
        chk("rst_err", DW'(err), DW'(0));
        step();
        rst_n = 1'b1;
        step();
        // fill to full
        for (int i = 0; i < ENTRIES; i++) begin
            xv = 1; xch = 2'd1; xd = DW'((i + 1) * 8'h11);
            #1;
            chk("fill_id", DW'(xid), DW'(i));
            step();
        end
        xv = 0;
        #1;
        chk("full_ready", DW'(xr), DW'(0));
        chk("full_count", DW'(cnt), DW'(8));
        // read-back id 3
        rr = 1; qv = 1; qid = 3; qch = 1;
        #1;
        chk("rb_req_ready", DW'(qr), DW'(1));
        step();
        qv = 0;
        #1;
        chk("rb_rtn_valid", DW'(rv), DW'(1));
        chk("rb_rtn_data", rd, DW'(8'h44));
        step();
        chk("rb_freed_id", DW'(xid), DW'(3));
        chk("rb_count", DW'(cnt), DW'(7));
        xv = 1; xch = 1; xd = DW'(8'h99);
        step();
        xv = 0;
        // backpressure on id 2, queued request to id 4
        rr = 0; qv = 1; qid = 2;
        step();
        qid = 4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_data", rd, DW'(8'h33));
            chk("bp_req_ready", DW'(qr), DW'(0));
            step();
        end
        rr = 1;
        #1;
        chk("bp_release_ready", DW'(qr), DW'(1));
        step();
        qv = 0;
        #1;
        chk("b2b_data", rd, DW'(8'h55));
        chk("b2b_count", DW'(cnt), DW'(7));
        step();
        // free id 5, refill 2 and 4, then stall on free id 5
        qv = 1; qid = 5;
        step();
        qv = 0;
        #1;
        chk("r5_data", rd, DW'(8'h66));
        step();
        xv = 1; xd = DW'(8'hB2);
        step();
        xd = DW'(8'hB4);
        step();
        xv = 0; qv = 1; qid = 5;
        #1;
        chk("stall_free0", DW'(qr), DW'(0));
        step();
        chk("stall_free1", DW'(qr), DW'(0));
        xv = 1; xd = DW'(8'hA5);
        #1;
        chk("stall_fill_id", DW'(xid), DW'(5));
        chk("stall_free2", DW'(qr), DW'(0));
        step();
        xv = 0;
        #1;
        chk("stall_go", DW'(qr), DW'(1));
        step();
        chk("stall_data", rd, DW'(8'hA5));
        chk("stall_pending", DW'(qr), DW'(0));
        step();
        qv = 0;
        // illegal requests
        qv = 1; qid = 9; qch = 1;
        #1;
        chk("ill9_ready", DW'(qr), DW'(1));
        step();
        qv = 0;
        #1;
        chk("ill9_data", rd, '0);
        chk("ill9_err", DW'(err), DW'(1));
        chk("ill9_count", DW'(cnt), DW'(7));
        step();
        qv = 1; qid = 0; qch = 2;
        #1;
        chk("illch_ready", DW'(qr), DW'(1));
        step();
        qv = 0;
        #1;
        chk("illch_data", rd, '0);
        chk("illch_count", DW'(cnt), DW'(7));
        step();
        // same-cycle allocation and return-free
        qv = 1; qid = 0; qch = 1;
        step();
        qv = 0; xv = 1; xch = 3; xd = DW'(8'h5A);
        #1;
        chk("conc_id", DW'(xid), DW'(5));
        step();
        xv = 0;
        #1;
        chk("conc_count", DW'(cnt), DW'(7));
        // reset while a return is in flight
        qv = 1; qid = 1; qch = 1;
        step();
        qv = 0;
        #1;
        chk("pre_rst_valid", DW'(rv), DW'(1));
        rst_n = 0;
        #1;
        chk("arst_valid", DW'(rv), DW'(0));
        chk("arst_count", DW'(cnt), DW'(0));
        chk("arst_err", DW'(err), DW'(0));
        chk("arst_ready", DW'(xr), DW'(1));
        step();
        rst_n = 1;
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            automatic int s = $urandom_range(0, ENTRIES - 1);
            automatic int pick = -1;
            xv = $urandom_range(0, 2) != 0;
            xch = 2'($urandom_range(0, 3));
            xd = {$urandom, $urandom, $urandom, $urandom};
            rr = $urandom_range(0, 3) != 0;
            qv = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) < 7) begin
                for (int k = 0; k < ENTRIES; k++)
                    if (pick < 0 && m_st[(s + k) % ENTRIES] == 1) pick = (s + k) % ENTRIES;
            end
            if (pick >= 0) begin
                qid = IDW'(pick);
                qch = $urandom_range(0, 19) == 0 ? 2'($urandom_range(0, 3)) : 2'(m_ch[pick]);
            end else begin
                qid = IDW'($urandom_range(0, 10));
                qch = 2'($urandom_range(0, 3));
            end
            step();
        end
        xv = 0; qv = 0; rr = 1;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
